// File: rtl/save_arb_pkg.sv
// save_arb_pkg
// Shared types and widths for the save-RAM arbiter slice: the arbiter FSM
// state enum, the requester identifiers and the backup-RAM address/data
// widths. No ports; imported by the interface, the top and the read pipe.
package save_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    LD  = 2'd0,
    RTC = 2'd1,
    RD  = 2'd2
  } req_id_e;

endpackage

// File: rtl/save_ram_arbiter_if.sv
// save_ram_arbiter_if
// Bundles every handshake and backup-RAM signal of the save-RAM arbiter.
// Signals:
//   ld_req/ld_addr/ld_data/ld_ack     save-load write requester
//   rtc_req/rtc_addr/rtc_data/rtc_ack RTC-restore write requester
//   rd_req/rd_addr/rd_ack/rd_valid/rd_data  save-unload read requester
//   bk_wr/bk_rtc_wr/bk_addr/bk_data/bk_q    backup RAM port
//   busy                              arbiter not idle
// Modports:
//   slave  - the arbiter side (takes requests, drives acks and the RAM port)
//   master - the requesters plus backup RAM side
interface save_ram_arbiter_if;
  import save_arb_pkg::*;

  logic  ld_req;
  addr_t ld_addr;
  data_t ld_data;
  logic  ld_ack;

  logic  rtc_req;
  addr_t rtc_addr;
  data_t rtc_data;
  logic  rtc_ack;

  logic  rd_req;
  addr_t rd_addr;
  logic  rd_ack;
  logic  rd_valid;
  data_t rd_data;

  logic  bk_wr;
  logic  bk_rtc_wr;
  addr_t bk_addr;
  data_t bk_data;
  data_t bk_q;

  logic  busy;

  modport slave (
    input  ld_req, ld_addr, ld_data,
    input  rtc_req, rtc_addr, rtc_data,
    input  rd_req, rd_addr,
    input  bk_q,
    output ld_ack, rtc_ack, rd_ack, rd_valid, rd_data,
    output bk_wr, bk_rtc_wr, bk_addr, bk_data,
    output busy
  );

  modport master (
    output ld_req, ld_addr, ld_data,
    output rtc_req, rtc_addr, rtc_data,
    output rd_req, rd_addr,
    output bk_q,
    input  ld_ack, rtc_ack, rd_ack, rd_valid, rd_data,
    input  bk_wr, bk_rtc_wr, bk_addr, bk_data,
    input  busy
  );

endinterface

// File: rtl/save_arb_rd_pipe.sv
// save_arb_rd_pipe
// Read-latency tracker for the save-RAM arbiter. A launch pulse (the read
// grant) walks down a RD_LATENCY-deep shift register; when it reaches the
// last stage bk_q is captured into rd_data and rd_valid pulses for one cycle.
// Ports:
//   clk_sys, reset  clock and synchronous active-high reset
//   launch          one-cycle pulse on the edge that grants a read
//   bk_q            backup RAM read data
//   done            high in the last latency cycle (capture happens next edge)
//   rd_valid        registered one-cycle valid pulse
//   rd_data         registered read data, held between reads
module save_arb_rd_pipe
  import save_arb_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic  clk_sys,
  input  logic  reset,
  input  logic  launch,
  input  data_t bk_q,
  output logic  done,
  output logic  rd_valid,
  output data_t rd_data
);

  logic [RD_LATENCY-1:0] stage_q, stage_d;
  logic                  rd_valid_q, rd_valid_d;
  data_t                 rd_data_q, rd_data_d;

  // The cast drops the oldest stage, which keeps the shift legal even for
  // a single-stage pipe.
  always_comb begin
    stage_d    = RD_LATENCY'({stage_q, launch});
    rd_valid_d = stage_q[RD_LATENCY-1];
    rd_data_d  = rd_data_q;
    if (stage_q[RD_LATENCY-1]) begin
      rd_data_d = bk_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stage_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      stage_q    <= stage_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign done     = stage_q[RD_LATENCY-1];
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/save_ram_arbiter.sv
// save_ram_arbiter
// Arbitrates two write requesters (save-load, RTC-restore) and one read
// requester (save-unload) onto a single backup-RAM port. Fixed priority
// ld > rtc > rd in IDLE; an access in progress is never pre-empted.
// Ports:
//   clk_sys  the single clock
//   reset    synchronous, active-high
//   bus      save_ram_arbiter_if.slave: requester handshakes, backup RAM
//            port and busy flag
// Parameters:
//   RD_LATENCY    cycles from bk_addr valid to bk_q valid (1..15)
//   WR_HOLD       cycles each write strobe is held (1..15)
//   STARVE_LIMIT  wait cycles before rtc/rd is promoted (aging build only)
// Optional feature:
//   SAVE_ARB_AGING_EN  adds saturating wait counters for rtc and rd; a
//                      requester whose counter reaches STARVE_LIMIT wins the
//                      next IDLE arbitration (rtc before rd).
module save_ram_arbiter
  import save_arb_pkg::*;
#(
  parameter int RD_LATENCY   = 2,
  parameter int WR_HOLD      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk_sys,
  input logic               reset,
  save_ram_arbiter_if.slave bus
);

  if (RD_LATENCY < 1 || RD_LATENCY > 15 || WR_HOLD < 1 || WR_HOLD > 15 ||
      STARVE_LIMIT < 1) begin : g_param_check
    $error("save_ram_arbiter: parameter out of range");
  end

  localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD - 1);

  arb_state_e state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       ld_ack_q, ld_ack_d;
  logic       rtc_ack_q, rtc_ack_d;
  logic       rd_ack_q, rd_ack_d;
  logic       bk_wr_q, bk_wr_d;
  logic       bk_rtc_wr_q, bk_rtc_wr_d;
  logic       busy_q, busy_d;
  addr_t      bk_addr_q, bk_addr_d;
  data_t      bk_data_q, bk_data_d;

  logic       grant_valid;
  req_id_e    grant_id;
  logic       rd_launch;
  logic       rd_done;

`ifdef SAVE_ARB_AGING_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] rtc_age_q, rtc_age_d;
  logic [AGE_W-1:0] rd_age_q, rd_age_d;
  logic             rtc_aged, rd_aged;

  assign rtc_aged = bus.rtc_req && (rtc_age_q == AGE_MAX);
  assign rd_aged  = bus.rd_req && (rd_age_q == AGE_MAX);

  // Counters only advance on IDLE edges where the requester lost; they
  // freeze while an access is in progress and clear when req drops.
  always_comb begin
    rtc_age_d = rtc_age_q;
    rd_age_d  = rd_age_q;
    if (!bus.rtc_req) begin
      rtc_age_d = '0;
    end else if (state_q == IDLE) begin
      if (grant_valid && grant_id == RTC) begin
        rtc_age_d = '0;
      end else if (rtc_age_q != AGE_MAX) begin
        rtc_age_d = rtc_age_q + 1'b1;
      end
    end
    if (!bus.rd_req) begin
      rd_age_d = '0;
    end else if (state_q == IDLE) begin
      if (grant_valid && grant_id == RD) begin
        rd_age_d = '0;
      end else if (rd_age_q != AGE_MAX) begin
        rd_age_d = rd_age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rtc_age_q <= '0;
      rd_age_q  <= '0;
    end else begin
      rtc_age_q <= rtc_age_d;
      rd_age_q  <= rd_age_d;
    end
  end
`endif

  // Grant selection, only acted on in IDLE. Aged requesters override the
  // fixed order when the aging feature is built in.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = LD;
    if (bus.ld_req) begin
      grant_valid = 1'b1;
      grant_id    = LD;
    end else if (bus.rtc_req) begin
      grant_valid = 1'b1;
      grant_id    = RTC;
    end else if (bus.rd_req) begin
      grant_valid = 1'b1;
      grant_id    = RD;
    end
`ifdef SAVE_ARB_AGING_EN
    if (rtc_aged) begin
      grant_valid = 1'b1;
      grant_id    = RTC;
    end else if (rd_aged) begin
      grant_valid = 1'b1;
      grant_id    = RD;
    end
`endif
  end

  // Next-state and registered-output logic. Acks default low so they are
  // single-cycle pulses; strobes are re-asserted each WRITE cycle until the
  // hold counter runs out.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    ld_ack_d    = 1'b0;
    rtc_ack_d   = 1'b0;
    rd_ack_d    = 1'b0;
    bk_wr_d     = 1'b0;
    bk_rtc_wr_d = 1'b0;
    bk_addr_d   = bk_addr_q;
    bk_data_d   = bk_data_q;
    rd_launch   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          case (grant_id)
            LD: begin
              state_d   = WRITE;
              hold_d    = HOLD_LAST;
              ld_ack_d  = 1'b1;
              bk_wr_d   = 1'b1;
              bk_addr_d = bus.ld_addr;
              bk_data_d = bus.ld_data;
            end
            RTC: begin
              state_d     = WRITE;
              hold_d      = HOLD_LAST;
              rtc_ack_d   = 1'b1;
              bk_rtc_wr_d = 1'b1;
              bk_addr_d   = bus.rtc_addr;
              bk_data_d   = bus.rtc_data;
            end
            RD: begin
              state_d   = READ;
              rd_ack_d  = 1'b1;
              bk_addr_d = bus.rd_addr;
              rd_launch = 1'b1;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
      WRITE: begin
        if (hold_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          hold_d      = hold_q - 4'd1;
          bk_wr_d     = bk_wr_q;
          bk_rtc_wr_d = bk_rtc_wr_q;
        end
      end
      READ: begin
        if (rd_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= 4'd0;
      ld_ack_q    <= 1'b0;
      rtc_ack_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      bk_wr_q     <= 1'b0;
      bk_rtc_wr_q <= 1'b0;
      busy_q      <= 1'b0;
      bk_addr_q   <= '0;
      bk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ld_ack_q    <= ld_ack_d;
      rtc_ack_q   <= rtc_ack_d;
      rd_ack_q    <= rd_ack_d;
      bk_wr_q     <= bk_wr_d;
      bk_rtc_wr_q <= bk_rtc_wr_d;
      busy_q      <= busy_d;
      bk_addr_q   <= bk_addr_d;
      bk_data_q   <= bk_data_d;
    end
  end

  save_arb_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk_sys (clk_sys),
    .reset   (reset),
    .launch  (rd_launch),
    .bk_q    (bus.bk_q),
    .done    (rd_done),
    .rd_valid(bus.rd_valid),
    .rd_data (bus.rd_data)
  );

  assign bus.ld_ack    = ld_ack_q;
  assign bus.rtc_ack   = rtc_ack_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.bk_wr     = bk_wr_q;
  assign bus.bk_rtc_wr = bk_rtc_wr_q;
  assign bus.bk_addr   = bk_addr_q;
  assign bus.bk_data   = bk_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_save_ram_arbiter.sv
// tb_save_ram_arbiter
// Directed bench for save_ram_arbiter with default parameters
// (RD_LATENCY=2, WR_HOLD=3, STARVE_LIMIT=8). The backup RAM is modelled
// with one register stage so bk_q follows bk_addr by one cycle; address
// 0x1FFFF reads 0x1234, every other address reads addr[15:0]^0x5A5A.
// Sample index i below means "just after the i-th edge counted from the
// edge that granted the request".
module tb_save_ram_arbiter;
  import save_arb_pkg::*;

  logic clk_sys = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  save_ram_arbiter_if bus ();

  save_ram_arbiter #(
    .RD_LATENCY  (2),
    .WR_HOLD     (3),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic data_t ram_model(input addr_t a);
    if (a == 17'h1FFFF) return 16'h1234;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk_sys) bus.bk_q <= ram_model(bus.bk_addr);

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    bus.ld_req   = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.rtc_req  = 1'b0;
    bus.rtc_addr = '0;
    bus.rtc_data = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    reset = 1'b1;
    tick;
    tick;
    total++;
    if ({bus.ld_ack, bus.rtc_ack, bus.rd_ack, bus.rd_valid, bus.bk_wr,
         bus.bk_rtc_wr, bus.busy} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want %b", {bus.ld_ack, bus.rtc_ack,
               bus.rd_ack, bus.rd_valid, bus.bk_wr, bus.bk_rtc_wr, bus.busy}, 7'b0);
    end
    total++;
    if ({bus.bk_addr, bus.bk_data, bus.rd_data} !== 49'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got addr=%h data=%h rd=%h want zeros",
               bus.bk_addr, bus.bk_data, bus.rd_data);
    end
    reset = 1'b0;
    tick;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single_write;
    logic [7:0] ack_m = '0;
    logic [7:0] wr_m = '0;
    logic [7:0] rtc_m = '0;
    logic [7:0] busy_m = '0;
    logic       bus_ok = 1'b1;
    bus.ld_addr = 17'h00010;
    bus.ld_data = 16'hBEEF;
    bus.ld_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.ld_ack === 1'b1) begin
        bus.ld_req  = 1'b0;
        bus.ld_addr = 17'h1F0F0;
        bus.ld_data = 16'h0000;
      end
      ack_m[i]  = bus.ld_ack;
      wr_m[i]   = bus.bk_wr;
      rtc_m[i]  = bus.bk_rtc_wr;
      busy_m[i] = bus.busy;
      if (bus.bk_wr === 1'b1 && (bus.bk_addr !== 17'h00010 || bus.bk_data !== 16'hBEEF))
        bus_ok = 1'b0;
    end
    total++;
    if (ack_m !== 8'h01) begin
      bad++;
      $display("[TB] FAIL wr_ack_pulse: got %b want %b", ack_m, 8'h01);
    end
    total++;
    if (wr_m !== 8'h07) begin
      bad++;
      $display("[TB] FAIL wr_strobe_len: got %b want %b", wr_m, 8'h07);
    end
    total++;
    if (rtc_m !== 8'h00) begin
      bad++;
      $display("[TB] FAIL wr_wrong_strobe: got %b want %b", rtc_m, 8'h00);
    end
    total++;
    if (busy_m !== 8'h07) begin
      bad++;
      $display("[TB] FAIL wr_busy: got %b want %b", busy_m, 8'h07);
    end
    total++;
    if (bus_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wr_addr_data_stable: got %b want 1", bus_ok);
    end
    total++;
    if ({bus.bk_addr, bus.bk_data} !== {17'h00010, 16'hBEEF}) begin
      bad++;
      $display("[TB] FAIL idle_retain: got addr=%h data=%h want 00010 beef",
               bus.bk_addr, bus.bk_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] ack_m = '0;
    logic [9:0] wr_m = '0;
    bus.ld_addr = 17'h00020;
    bus.ld_data = 16'h1111;
    bus.ld_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      ack_m[i] = bus.ld_ack;
      wr_m[i]  = bus.bk_wr;
      if (i == 9) bus.ld_req = 1'b0;
    end
    for (int i = 0; i < 4; i++) tick;
    total++;
    if (ack_m !== 10'h111) begin
      bad++;
      $display("[TB] FAIL b2b_ack_spacing: got %b want %b", ack_m, 10'h111);
    end
    total++;
    if (wr_m !== 10'h377) begin
      bad++;
      $display("[TB] FAIL b2b_strobe: got %b want %b", wr_m, 10'h377);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_idle: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_priority;
    int    ld_at = -1;
    int    rtc_at = -1;
    int    rd_at = -1;
    int    rv_at = -1;
    int    wr_cnt = 0;
    int    rtc_cnt = 0;
    int    overlap = 0;
    logic  rtc_ok = 1'b1;
    data_t rv_data = '0;
    bus.ld_addr  = 17'h00100;
    bus.ld_data  = 16'hAAAA;
    bus.rtc_addr = 17'h00200;
    bus.rtc_data = 16'hBBBB;
    bus.rd_addr  = 17'h00ABC;
    bus.ld_req   = 1'b1;
    bus.rtc_req  = 1'b1;
    bus.rd_req   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (bus.ld_ack === 1'b1) begin
        ld_at = i;
        bus.ld_req = 1'b0;
      end
      if (bus.rtc_ack === 1'b1) begin
        rtc_at = i;
        bus.rtc_req = 1'b0;
      end
      if (bus.rd_ack === 1'b1) begin
        rd_at = i;
        bus.rd_req = 1'b0;
      end
      if (bus.rd_valid === 1'b1) begin
        rv_at   = i;
        rv_data = bus.rd_data;
      end
      if (bus.bk_wr === 1'b1) wr_cnt++;
      if (bus.bk_rtc_wr === 1'b1) begin
        rtc_cnt++;
        if (bus.bk_addr !== 17'h00200 || bus.bk_data !== 16'hBBBB) rtc_ok = 1'b0;
      end
      if (bus.bk_wr === 1'b1 && bus.bk_rtc_wr === 1'b1) overlap++;
    end
    total++;
    if (ld_at !== 0) begin
      bad++;
      $display("[TB] FAIL prio_ld_first: got %0d want 0", ld_at);
    end
    total++;
    if (rtc_at !== 4) begin
      bad++;
      $display("[TB] FAIL prio_rtc_second: got %0d want 4", rtc_at);
    end
    total++;
    if (rd_at !== 8) begin
      bad++;
      $display("[TB] FAIL prio_rd_third: got %0d want 8", rd_at);
    end
    total++;
    if (rv_at !== 10) begin
      bad++;
      $display("[TB] FAIL prio_rd_valid_time: got %0d want 10", rv_at);
    end
    // 0x0ABC ^ 0x5A5A = 0x50E6
    total++;
    if (rv_data !== 16'h50E6) begin
      bad++;
      $display("[TB] FAIL prio_rd_data: got %h want 50e6", rv_data);
    end
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("[TB] FAIL prio_overlap: got %0d want 0", overlap);
    end
    total++;
    if (wr_cnt !== 3 || rtc_cnt !== 3) begin
      bad++;
      $display("[TB] FAIL prio_strobe_cnt: got wr=%0d rtc=%0d want 3 3", wr_cnt, rtc_cnt);
    end
    total++;
    if (rtc_ok !== 1'b1) begin
      bad++;
      $display("[TB] FAIL prio_rtc_bus: got %b want 1", rtc_ok);
    end
  endtask

  task automatic test_read;
    logic [5:0] ack_m = '0;
    logic [5:0] val_m = '0;
    logic [5:0] busy_m = '0;
    data_t      data_before = '0;
    data_t      data_at_valid = '0;
    bus.rd_addr = 17'h1FFFF;
    bus.rd_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.rd_ack === 1'b1) bus.rd_req = 1'b0;
      ack_m[i]  = bus.rd_ack;
      val_m[i]  = bus.rd_valid;
      busy_m[i] = bus.busy;
      if (i == 1) data_before = bus.rd_data;
      if (bus.rd_valid === 1'b1) data_at_valid = bus.rd_data;
    end
    total++;
    if (ack_m !== 6'b000001) begin
      bad++;
      $display("[TB] FAIL rd_ack: got %b want %b", ack_m, 6'b000001);
    end
    total++;
    if (val_m !== 6'b000100) begin
      bad++;
      $display("[TB] FAIL rd_valid_pulse: got %b want %b", val_m, 6'b000100);
    end
    total++;
    if (busy_m !== 6'b000011) begin
      bad++;
      $display("[TB] FAIL rd_busy: got %b want %b", busy_m, 6'b000011);
    end
    total++;
    if (data_before !== 16'h50E6) begin
      bad++;
      $display("[TB] FAIL rd_data_hold_prev: got %h want 50e6", data_before);
    end
    total++;
    if (data_at_valid !== 16'h1234 || bus.rd_data !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL rd_data: got %h then %h want 1234", data_at_valid, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_write;
    bus.ld_addr = 17'h00300;
    bus.ld_data = 16'hCCCC;
    bus.ld_req  = 1'b1;
    tick;
    total++;
    if ({bus.ld_ack, bus.bk_wr} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL rst_mid_first_grant: got %b want 11", {bus.ld_ack, bus.bk_wr});
    end
    tick;
    reset = 1'b1;
    tick;
    total++;
    if ({bus.ld_ack, bus.bk_wr, bus.busy} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rst_mid_abort: got %b want 000", {bus.ld_ack, bus.bk_wr, bus.busy});
    end
    total++;
    if (bus.bk_addr !== 17'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_addr: got %h want 0", bus.bk_addr);
    end
    reset = 1'b0;
    tick;
    total++;
    if ({bus.ld_ack, bus.bk_wr, bus.bk_addr} !== {2'b11, 17'h00300}) begin
      bad++;
      $display("[TB] FAIL rst_mid_regrant: got ack=%b wr=%b addr=%h want 1 1 00300",
               bus.ld_ack, bus.bk_wr, bus.bk_addr);
    end
    bus.ld_req = 1'b0;
    for (int i = 0; i < 5; i++) tick;
  endtask

  task automatic test_rtc_pulse;
    int rtc_ack_cnt = 0;
    int rtc_wr_cnt = 0;
    int wr_cnt = 0;
    bus.ld_addr  = 17'h00400;
    bus.ld_data  = 16'hDDDD;
    bus.ld_req   = 1'b1;
    tick;
    if (bus.bk_wr === 1'b1) wr_cnt++;
    bus.ld_req   = 1'b0;
    bus.rtc_addr = 17'h00500;
    bus.rtc_data = 16'h5555;
    bus.rtc_req  = 1'b1;
    for (int i = 1; i < 10; i++) begin
      tick;
      if (i == 1) bus.rtc_req = 1'b0;
      if (bus.rtc_ack === 1'b1) rtc_ack_cnt++;
      if (bus.bk_rtc_wr === 1'b1) rtc_wr_cnt++;
      if (bus.bk_wr === 1'b1) wr_cnt++;
    end
    total++;
    if (rtc_ack_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL rtc_pulse_ack: got %0d want 0", rtc_ack_cnt);
    end
    total++;
    if (rtc_wr_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL rtc_pulse_strobe: got %0d want 0", rtc_wr_cnt);
    end
    total++;
    if (wr_cnt !== 3) begin
      bad++;
      $display("[TB] FAIL rtc_pulse_ld_write: got %0d want 3", wr_cnt);
    end
  endtask

  task automatic test_aging;
    int   ld_cnt = 0;
    int   rd_cnt = 0;
    int   rd_at = -1;
    logic rd_seen = 1'b0;
    bus.ld_addr = 17'h00600;
    bus.ld_data = 16'h6666;
    bus.rd_addr = 17'h00700;
    bus.ld_req  = 1'b1;
    bus.rd_req  = 1'b1;
`ifdef SAVE_ARB_AGING_EN
    for (int i = 0; i < 60 && !rd_seen; i++) begin
      tick;
      if (bus.ld_ack === 1'b1) ld_cnt++;
      if (bus.rd_ack === 1'b1) begin
        rd_seen = 1'b1;
        rd_at   = i;
        bus.rd_req = 1'b0;
        bus.ld_req = 1'b0;
      end
    end
    bus.rd_req = 1'b0;
    bus.ld_req = 1'b0;
    total++;
    if (rd_seen !== 1'b1) begin
      bad++;
      $display("[TB] FAIL aging_rd_granted: got %b want 1", rd_seen);
    end
    total++;
    if (ld_cnt !== 8) begin
      bad++;
      $display("[TB] FAIL aging_ld_before_rd: got %0d want 8", ld_cnt);
    end
    total++;
    if (rd_at !== 32) begin
      bad++;
      $display("[TB] FAIL aging_rd_time: got %0d want 32", rd_at);
    end
`else
    for (int i = 0; i < 120; i++) begin
      tick;
      if (bus.ld_ack === 1'b1) ld_cnt++;
      if (bus.rd_ack === 1'b1) begin
        rd_cnt++;
        bus.rd_req = 1'b0;
      end
      if (i == 119) begin
        bus.ld_req = 1'b0;
        bus.rd_req = 1'b0;
      end
    end
    total++;
    if (rd_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL noaging_rd_starved: got %0d want 0", rd_cnt);
    end
    total++;
    if (ld_cnt !== 30) begin
      bad++;
      $display("[TB] FAIL noaging_ld_grants: got %0d want 30", ld_cnt);
    end
`endif
    for (int i = 0; i < 8; i++) tick;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL aging_final_idle: got %b want 0", bus.busy);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_back_to_back;
    test_priority;
    test_read;
    test_reset_mid_write;
    test_rtc_pulse;
    test_aging;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
